node_stream_serializer: RTL and testbench

- Write-side (wclk domain) transmitter for the internal-node load path.
- Accepts wide internal-node words (index/median pairs) through a valid/ready handshake and splits each into NUM_CHUNKS DSIZE-bit chunks, low chunk first.
- Enqueues chunks into the SyncFIFO write port, honouring sFULL_N and an external stall.
- The clk-side aggregator reassembles the chunks in the same order, so this block is its exact inverse.

---
 rtl/node_stream_serializer_pkg.sv | 17 +
 rtl/node_chunk_shifter.sv | 38 +++
 rtl/node_stream_serializer.sv | 92 +++++++++
 tb/tb_node_stream_serializer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/node_stream_serializer_pkg.sv
// Shared constants and state encoding for the internal-node write-side load path.
// NODE_DSIZE/NODE_WIDTH must stay in step with the clk-side aggregator and node tree.
package node_stream_serializer_pkg;

    localparam int NODE_DSIZE       = 11;
    localparam int NODE_CHUNKS      = 2;
    localparam int NODE_WIDTH       = NODE_DSIZE * NODE_CHUNKS;
    localparam int NODE_COUNT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DONE
    } ser_state_e;

endpackage

// File: rtl/node_chunk_shifter.sv
// Holds one wide node word and presents it DSIZE bits at a time, low chunk first.
// last_chunk flags that the chunk currently on the output is the final one of the word.
module node_chunk_shifter #(
    parameter int DSIZE      = 11,
    parameter int NUM_CHUNKS = 2
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic                          load,
    input  logic                          shift,
    input  logic [DSIZE*NUM_CHUNKS-1:0]   load_data,
    output logic [DSIZE-1:0]              chunk,
    output logic                          last_chunk
);

    localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    logic [DSIZE*NUM_CHUNKS-1:0] shift_reg;
    logic [CNT_W-1:0]            chunk_cnt_reg;

    assign chunk      = shift_reg[DSIZE-1:0];
    assign last_chunk = (chunk_cnt_reg == CNT_W'(NUM_CHUNKS - 1));

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            shift_reg     <= '0;
            chunk_cnt_reg <= '0;
        end else if (load) begin
            shift_reg     <= load_data;
            chunk_cnt_reg <= '0;
        end else if (shift) begin
            // Zero fill keeps the output quiet once a word has drained.
            shift_reg     <= shift_reg >> DSIZE;
            chunk_cnt_reg <= last_chunk ? '0 : chunk_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/node_stream_serializer.sv
// Write-side transmitter: fetches wide node words and enqueues them as DSIZE chunks
// into the SyncFIFO, low chunk first, exactly mirroring the clk-side aggregator.
module node_stream_serializer
    import node_stream_serializer_pkg::*;
#(
    parameter int DSIZE       = NODE_DSIZE,
    parameter int NUM_CHUNKS  = NODE_CHUNKS,
    parameter int COUNT_WIDTH = NODE_COUNT_WIDTH
) (
    input  logic                         wclk,
    input  logic                         wrst_n,
    input  logic                         start,
    input  logic [COUNT_WIDTH-1:0]       total_words,
    input  logic [DSIZE*NUM_CHUNKS-1:0]  src_data,
    input  logic                         src_valid,
    output logic                         src_ready,
    input  logic                         stall,
    input  logic                         fifo_full_n,
    output logic                         fifo_enq,
    output logic [DSIZE-1:0]             fifo_wdata,
    output logic                         busy,
    output logic                         done,
    output logic [COUNT_WIDTH-1:0]       words_sent
);

    ser_state_e             state_reg;
    logic [COUNT_WIDTH-1:0] target_reg;
    logic [COUNT_WIDTH-1:0] words_sent_reg;
    logic [COUNT_WIDTH-1:0] sent_inc;
    logic                   accept;
    logic                   enq_ok;
    logic                   last_chunk;

    assign src_ready  = (state_reg == FETCH);
    assign accept     = src_ready && src_valid;
    // Gating with wrst_n keeps the strobe low even while reset is being applied.
    assign enq_ok     = wrst_n && (state_reg == SEND) && fifo_full_n && !stall;
    assign fifo_enq   = enq_ok;
    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign words_sent = words_sent_reg;
    assign sent_inc   = words_sent_reg + COUNT_WIDTH'(1);

    node_chunk_shifter #(
        .DSIZE      (DSIZE),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) u_shifter (
        .wclk       (wclk),
        .wrst_n     (wrst_n),
        .load       (accept),
        .shift      (enq_ok),
        .load_data  (src_data),
        .chunk      (fifo_wdata),
        .last_chunk (last_chunk)
    );

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_reg      <= IDLE;
            target_reg     <= '0;
            words_sent_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        target_reg     <= total_words;
                        words_sent_reg <= '0;
                        state_reg      <= (total_words == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (enq_ok && last_chunk) begin
                        words_sent_reg <= sent_inc;
                        state_reg      <= (sent_inc == target_reg) ? DONE : FETCH;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_node_stream_serializer.sv
// Randomized bench for node_stream_serializer against a transaction-level model of
// the transfer (words pending, chunks left in the current word, done owed).
module tb_node_stream_serializer;

    localparam int DS = 11;
    localparam int NC = 2;
    localparam int CW = 8;
    localparam int WW = DS * NC;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          start;
    logic [CW-1:0] total_words;
    logic [WW-1:0] src_data;
    logic          src_valid;
    logic          src_ready;
    logic          stall;
    logic          fifo_full_n;
    logic          fifo_enq;
    logic [DS-1:0] fifo_wdata;
    logic          busy;
    logic          done;
    logic [CW-1:0] words_sent;

    always #5 wclk = ~wclk;

    node_stream_serializer dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .start       (start),
        .total_words (total_words),
        .src_data    (src_data),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .stall       (stall),
        .fifo_full_n (fifo_full_n),
        .fifo_enq    (fifo_enq),
        .fifo_wdata  (fifo_wdata),
        .busy        (busy),
        .done        (done),
        .words_sent  (words_sent)
    );

    int err_cnt = 0;
    int chk_cnt = 0;

    // Reference model of the transfer
    bit            m_active, m_need, m_done;
    int            m_pending, m_target, m_sent;
    logic [WW-1:0] m_word;

    logic [DS-1:0] rx_q[$];
    int            enq_cnt, done_cnt;
    bit            last_hs;
    logic [WW-1:0] words [64];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DS-1:0] chunk_of(input logic [WW-1:0] w, input int idx);
        return w[idx*DS +: DS];
    endfunction

    task automatic model_reset();
        m_active = 0; m_need = 0; m_done = 0;
        m_pending = 0; m_target = 0; m_sent = 0; m_word = '0;
    endtask

    task automatic clear_stats();
        rx_q.delete();
        enq_cnt = 0;
        done_cnt = 0;
    endtask

    // Inputs are set just after a negedge; sample 1 time unit later, then advance the model.
    task automatic tick();
        bit exp_enq;
        #1;
        last_hs = 0;
        if (!wrst_n) begin
            check_val("enq_in_reset", {31'd0, fifo_enq}, 32'd0);
            model_reset();
        end else begin
            exp_enq = (m_pending > 0) && fifo_full_n && !stall;
            check_val("src_ready", {31'd0, src_ready}, {31'd0, m_need});
            check_val("fifo_enq", {31'd0, fifo_enq}, {31'd0, exp_enq});
            check_val("busy", {31'd0, busy}, {31'd0, m_active});
            check_val("done", {31'd0, done}, {31'd0, m_done});
            check_val("words_sent", {24'd0, words_sent}, m_sent);
            if (m_pending > 0)
                check_val("fifo_wdata", {21'd0, fifo_wdata}, {21'd0, chunk_of(m_word, NC - m_pending)});
            if (fifo_enq) begin
                rx_q.push_back(fifo_wdata);
                enq_cnt++;
            end
            if (done) done_cnt++;
            last_hs = src_valid && src_ready;
            if (m_done) begin
                m_done = 0;
                m_active = 0;
            end else if (!m_active) begin
                if (start) begin
                    m_active = 1;
                    m_target = int'(total_words);
                    m_sent = 0;
                    if (total_words == 0) m_done = 1;
                    else m_need = 1;
                end
            end else if (m_need) begin
                if (src_valid) begin
                    m_word = src_data;
                    m_pending = NC;
                    m_need = 0;
                end
            end else if (exp_enq) begin
                m_pending--;
                if (m_pending == 0) begin
                    m_sent++;
                    if (m_sent == m_target) m_done = 1;
                    else m_need = 1;
                end
            end
        end
        @(negedge wclk);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_finished"}, {31'd0, done_cnt != d0}, 32'd1);
    endtask

    task automatic begin_transfer(input logic [CW-1:0] tw);
        total_words = tw;
        start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        logic [WW-1:0] w;
        int widx;
        wrst_n = 0; start = 0; total_words = '0; src_data = '0;
        src_valid = 0; stall = 0; fifo_full_n = 1;
        model_reset();
        clear_stats();
        @(negedge wclk);
        tick();
        tick();
        wrst_n = 1;
        check_val("reset_wdata", {21'd0, fifo_wdata}, 32'd0);
        tick();

        // Single word, no backpressure
        clear_stats();
        src_valid = 1; src_data = 22'h000802;
        begin_transfer(8'd1);
        run_until_done("single", 20);
        check_val("single_count", rx_q.size(), 32'd2);
        check_val("single_c0", {21'd0, rx_q[0]}, 32'd2);
        check_val("single_c1", {21'd0, rx_q[1]}, 32'd1);
        check_val("single_words", {24'd0, words_sent}, 32'd1);

        // Full FIFO hold during SEND
        clear_stats();
        src_data = 22'h1FFFFF;
        begin_transfer(8'd1);
        tick();
        fifo_full_n = 0;
        repeat (5) tick();
        check_val("hold_wdata", {21'd0, fifo_wdata}, 32'h7FF);
        check_val("hold_no_enq", enq_cnt, 32'd0);
        fifo_full_n = 1;
        run_until_done("hold", 20);
        check_val("hold_c0", {21'd0, rx_q[0]}, 32'h7FF);
        check_val("hold_c1", {21'd0, rx_q[1]}, 32'h3FF);

        // Zero-length transfer
        clear_stats();
        begin_transfer(8'd0);
        tick();
        tick();
        check_val("zero_done", done_cnt, 32'd1);
        check_val("zero_enq", enq_cnt, 32'd0);
        check_val("zero_words", {24'd0, words_sent}, 32'd0);

        // Start while busy is ignored
        clear_stats();
        src_data = WW'($urandom);
        begin_transfer(8'd3);
        tick();
        total_words = 8'd7;
        start = 1;
        tick();
        start = 0;
        run_until_done("busy_start", 40);
        tick();
        check_val("busy_start_enq", enq_cnt, 32'd6);
        check_val("busy_start_done", done_cnt, 32'd1);
        check_val("busy_start_words", {24'd0, words_sent}, 32'd3);

        // Reset after the first chunk of a word
        clear_stats();
        begin_transfer(8'd1);
        tick();
        tick();
        check_val("mid_first_enq", enq_cnt, 32'd1);
        wrst_n = 0;
        tick();
        wrst_n = 1;
        check_val("mid_busy", {31'd0, busy}, 32'd0);
        check_val("mid_ready", {31'd0, src_ready}, 32'd0);
        check_val("mid_wdata", {21'd0, fifo_wdata}, 32'd0);
        check_val("mid_words", {24'd0, words_sent}, 32'd0);
        clear_stats();
        w = WW'($urandom);
        src_data = w;
        begin_transfer(8'd1);
        run_until_done("mid_fresh", 20);
        check_val("mid_fresh_c0", {21'd0, rx_q[0]}, {21'd0, chunk_of(w, 0)});
        check_val("mid_fresh_c1", {21'd0, rx_q[1]}, {21'd0, chunk_of(w, 1)});

        // Streaming 64 words with random stall, full and source gaps
        clear_stats();
        for (int i = 0; i < 64; i++) words[i] = WW'($urandom);
        src_valid = 0;
        begin_transfer(8'd64);
        widx = 0;
        for (int n = 0; n < 3000 && done_cnt == 0; n++) begin
            src_valid   = (widx < 64) && ($urandom % 2 == 1);
            src_data    = words[(widx < 64) ? widx : 63];
            stall       = ($urandom % 2 == 1);
            fifo_full_n = ($urandom % 4 != 0);
            tick();
            if (last_hs) widx++;
        end
        check_val("stream_finished", done_cnt, 32'd1);
        stall = 0; fifo_full_n = 1; src_valid = 0;
        repeat (3) tick();
        check_val("stream_chunks", rx_q.size(), 32'd128);
        for (int i = 0; i < 64 && rx_q.size() >= 2 * (i + 1); i++)
            check_val("stream_word", {10'd0, rx_q[2*i+1], rx_q[2*i]}, {10'd0, words[i]});
        check_val("stream_words", {24'd0, words_sent}, 32'd64);
        check_val("stream_done_once", done_cnt, 32'd1);

        // Maximum length, no wrap, words_sent holds afterwards
        clear_stats();
        src_valid = 1;
        src_data = WW'($urandom);
        begin_transfer(8'd255);
        run_until_done("max", 1200);
        repeat (4) tick();
        check_val("max_words", {24'd0, words_sent}, 32'd255);
        check_val("max_enq", enq_cnt, 32'd510);
        check_val("max_done_once", done_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
